// File: rtl/softmax_row_sender.sv
// Softmax input framer: scales and saturates QK scores to Q8.7, applies the causal
// mask and sends each N-score row as one softmax job, waiting for done between rows.
module softmax_row_sender #(
    parameter int N     = 256,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_causal_i,
    input  logic                   row_clr_i,
    input  logic                   s_valid_i,
    input  logic [ACC_W-1:0]       s_data_i,
    output logic                   s_ready_o,
    output logic                   sm_start_o,
    output logic                   sm_valid_o,
    output logic [OUT_W-1:0]       sm_data_o,
    input  logic                   sm_ready_i,
    input  logic                   sm_done_i,
    output logic [$clog2(N)-1:0]   row_idx_o,
    output logic                   busy_o
);

    localparam int IW = $clog2(N);

    localparam logic [IW:0]             N_BEATS  = (IW+1)'(N);
    localparam logic [IW:0]             BEAT_ONE = {{IW{1'b0}}, 1'b1};
    localparam logic [IW-1:0]           ROW_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] POS_LIM  = ACC_W'((32'sd1 <<< (OUT_W-1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] NEG_LIM  = -POS_LIM;
    localparam logic [OUT_W-1:0]        SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        SAT_NEG  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]        MASK_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IW-1:0]    row_cnt_r;
    logic [IW-1:0]    q_r;
    logic             causal_r;
    logic             clr_pend_r;
    logic [IW:0]      beat_cnt_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic             start_r;
    logic             busy_r;
    logic             ready_s;
    logic             accept_s;
    logic             beat_xfer_s;
    logic             last_xfer_s;
    logic             masked_s;
    logic [OUT_W-1:0] beat_data_s;

    // The most negative code is reserved for the mask, so negative saturation stops one above it.
    function automatic logic [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] score);
        logic signed [ACC_W-1:0] t;
        t = score >>> SHIFT;
        if (t > POS_LIM) begin
            scale_sat = SAT_POS;
        end else if (t < NEG_LIM) begin
            scale_sat = SAT_NEG;
        end else begin
            scale_sat = t[OUT_W-1:0];
        end
    endfunction

    assign masked_s    = causal_r & (beat_cnt_r > {1'b0, q_r});
    assign beat_data_s = masked_s ? MASK_VAL : scale_sat($signed(s_data_i));

    // Next-state and handshake decode.
    always_comb begin
        state_s     = state_r;
        ready_s     = 1'b0;
        beat_xfer_s = out_valid_r & sm_ready_i;
        last_xfer_s = beat_xfer_s & (beat_cnt_r == N_BEATS);
        case (state_r)
            IDLE: begin
                if (s_valid_i) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                state_s = SEND;
            end
            SEND: begin
                ready_s = (beat_cnt_r < N_BEATS) & (~out_valid_r | sm_ready_i);
                if (last_xfer_s) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = SEND;
                end
            end
            WAIT_DONE: begin
                if (sm_done_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        accept_s = ready_s & s_valid_i;
    end

    // State register plus registered start/busy flags derived from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            start_r <= (state_s == START);
            busy_r  <= (state_s != IDLE);
        end
    end

    // Per-row context and beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_r        <= {IW{1'b0}};
            causal_r   <= 1'b0;
            beat_cnt_r <= {(IW+1){1'b0}};
        end else if (state_r == START) begin
            q_r        <= row_cnt_r;
            causal_r   <= cfg_causal_i;
            beat_cnt_r <= {(IW+1){1'b0}};
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Single-entry output register toward softmax.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= beat_data_s;
        end else if (beat_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // A clear during a started row must also stop that row's done from advancing the counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_pend_r <= 1'b0;
        end else if (row_clr_i && (state_r != IDLE)) begin
            clr_pend_r <= 1'b1;
        end else if (state_r == IDLE) begin
            clr_pend_r <= 1'b0;
        end else begin
            clr_pend_r <= clr_pend_r;
        end
    end

    // Query-row counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_cnt_r <= {IW{1'b0}};
        end else if (row_clr_i) begin
            row_cnt_r <= {IW{1'b0}};
        end else if ((state_r == WAIT_DONE) && sm_done_i) begin
            row_cnt_r <= clr_pend_r ? {IW{1'b0}} : (row_cnt_r + ROW_ONE);
        end else begin
            row_cnt_r <= row_cnt_r;
        end
    end

    assign s_ready_o  = ready_s;
    assign sm_start_o = start_r;
    assign sm_valid_o = out_valid_r;
    assign sm_data_o  = out_data_r;
    assign row_idx_o  = row_cnt_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_softmax_row_sender.sv
// Directed bench for softmax_row_sender: vector table for arithmetic, hand sequences for framing.
module tb_softmax_row_sender;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_causal;
    logic        row_clr;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic        sm_start;
    logic        sm_valid;
    logic [15:0] sm_data;
    logic        sm_ready = 1'b1;
    logic        sm_done;
    logic [7:0]  row_idx;
    logic        busy;

    logic        s8_valid;
    logic        s8_ready;
    logic        s8_start;
    logic        s8_valid_o;
    logic [15:0] s8_data_o;
    logic        s8_done;
    logic [2:0]  s8_row;
    logic        s8_busy;

    always #5 clk = ~clk;

    softmax_row_sender dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_causal_i(cfg_causal), .row_clr_i(row_clr),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .sm_start_o(sm_start), .sm_valid_o(sm_valid), .sm_data_o(sm_data),
        .sm_ready_i(sm_ready), .sm_done_i(sm_done), .row_idx_o(row_idx), .busy_o(busy)
    );

    softmax_row_sender #(.N(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_causal_i(1'b0), .row_clr_i(1'b0),
        .s_valid_i(s8_valid), .s_data_i(24'd0), .s_ready_o(s8_ready),
        .sm_start_o(s8_start), .sm_valid_o(s8_valid_o), .sm_data_o(s8_data_o),
        .sm_ready_i(1'b1), .sm_done_i(s8_done), .row_idx_o(s8_row), .busy_o(s8_busy)
    );

    typedef struct packed {
        logic [23:0] score;
        logic [15:0] exp;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [23:0] scores [N];
    logic [15:0] expv [N];
    logic [15:0] got [N];
    int          got_n = 0;
    int          starts = 0;
    int          start_cyc = 0;
    int          first_cyc = 0;
    bit          rand_ready = 1'b0;
    bit          hold_chk = 1'b0;
    logic [15:0] held_data = 16'd0;
    vec_t        vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        sm_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Downstream monitor: collects beats, counts starts, checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (hold_chk) check("stall_hold", {15'd0, sm_valid, sm_data}, {15'd0, 1'b1, held_data});
            hold_chk  = sm_valid && !sm_ready;
            held_data = sm_data;
            if (sm_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (sm_valid && sm_ready) begin
                if (got_n == 0) first_cyc = cyc;
                if (got_n < N) got[got_n] = sm_data;
                got_n++;
            end
        end else begin
            hold_chk = 1'b0;
        end
    end

    // kind 0: uniform 102400; kind 1: 800 with causal q; kind 2: ramp k*8
    task automatic fill_row(input int kind, input int q);
        for (int k = 0; k < N; k++) begin
            if (kind == 0) begin
                scores[k] = 24'd102400;
                expv[k]   = 16'h3200;
            end else if (kind == 1) begin
                scores[k] = 24'd800;
                expv[k]   = (k <= q) ? 16'h0064 : 16'h8000;
            end else begin
                scores[k] = 24'(k * 8);
                expv[k]   = 16'(k);
            end
        end
    endtask

    task automatic send_row(input bit causal, input int done_delay, input int clr_at,
                            input bit clr_done, input logic [7:0] exp_row, input int abort_at);
        int idx;
        int guard;
        bit cleared;
        bit quiet;
        got_n = 0; starts = 0; idx = 0; guard = 0; cleared = 1'b0;
        cfg_causal = causal;
        s_data     = scores[0];
        s_valid    = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 32'(s_ready), 32'd0);
        while (idx < N && idx != abort_at && guard < 4000) begin
            if (s_ready) idx++;
            @(posedge clk); #1;
            row_clr = 1'b0;
            if (!cleared && idx == clr_at) begin
                row_clr = 1'b1;
                cleared = 1'b1;
            end
            if (idx < N) s_data = scores[idx];
            guard++;
            @(negedge clk);
        end
        if (idx == abort_at) begin
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("rst_outputs_zero", {6'd0, sm_start, sm_valid, sm_data, s_ready, row_idx},
                  32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            s_valid = 1'b0;
            row_clr = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end
        check("accept_count", 32'(idx), 32'(N));
        @(posedge clk); #1;
        row_clr = 1'b0;
        guard = 0;
        while (got_n < N && guard < 4000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("beat_count", 32'(got_n), 32'(N));
        quiet = 1'b1;
        for (int k = 0; k < done_delay; k++) begin
            @(negedge clk);
            if (s_ready || sm_valid || sm_start || !busy) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("wait_done_quiet", 32'(quiet), 32'd1);
        sm_done = 1'b1;
        row_clr = clr_done;
        @(posedge clk); #1;
        sm_done = 1'b0;
        row_clr = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("row_idx", 32'(row_idx), 32'(exp_row));
        check("start_count", 32'(starts), 32'd1);
        check("first_beat_delay", 32'(first_cyc > start_cyc), 32'd1);
        for (int k = 0; k < N; k++) check($sformatf("beat%0d", k), 32'(got[k]), 32'(expv[k]));
        @(posedge clk); #1;
    endtask

    initial begin
        int guard;
        vt[0]  = '{24'd102400,  16'h3200};
        vt[1]  = '{24'd800,     16'h0064};
        vt[2]  = '{24'h7FFFFF,  16'h7FFF};
        vt[3]  = '{24'h800000,  16'h8001};
        vt[4]  = '{24'hFFFFF8,  16'hFFFF};
        vt[5]  = '{24'h000000,  16'h0000};
        vt[6]  = '{24'h03FFF8,  16'h7FFF};
        vt[7]  = '{24'h040000,  16'h7FFF};
        vt[8]  = '{24'hFC0008,  16'h8001};
        vt[9]  = '{24'hFC0000,  16'h8001};
        vt[10] = '{24'h000007,  16'h0000};
        vt[11] = '{24'hFFFFFF,  16'hFFFF};
        vt[12] = '{24'hFFFFF7,  16'hFFFE};
        vt[13] = '{24'h03FFFF,  16'h7FFF};
        vt[14] = '{24'hFFFCE0,  16'hFF9C};

        rst_n = 1'b0; cfg_causal = 1'b0; row_clr = 1'b0; s_valid = 1'b0;
        s_data = 24'd0; sm_done = 1'b0; s8_valid = 1'b0; s8_done = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("reset_start", 32'(sm_start), 32'd0);
        check("reset_valid", 32'(sm_valid), 32'd0);
        check("reset_data", 32'(sm_data), 32'd0);
        check("reset_ready", 32'(s_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_row_idx", 32'(row_idx), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_stays", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // arithmetic vectors at the head of row 0, remainder 102400
        fill_row(0, 0);
        for (int v = 0; v < 15; v++) begin
            scores[v] = vt[v].score;
            expv[v]   = vt[v].exp;
        end
        send_row(1'b0, 5, -1, 1'b0, 8'd1, -1);

        row_clr = 1'b1;
        @(posedge clk); #1;
        row_clr = 1'b0;
        @(negedge clk);
        check("clr_idle_row_idx", 32'(row_idx), 32'd0);
        @(posedge clk); #1;

        fill_row(1, 0);
        send_row(1'b1, 3, -1, 1'b0, 8'd1, -1);

        rand_ready = 1'b1;
        fill_row(2, 0);
        send_row(1'b0, 300, -1, 1'b0, 8'd2, -1);
        send_row(1'b0, 2, -1, 1'b0, 8'd3, -1);
        send_row(1'b0, 2, -1, 1'b0, 8'd4, -1);
        send_row(1'b0, 2, -1, 1'b0, 8'd5, -1);
        rand_ready = 1'b0;

        fill_row(1, 5);
        send_row(1'b1, 2, -1, 1'b0, 8'd6, -1);

        // clear mid-row: row keeps q=6, following row index is 0
        fill_row(1, 6);
        send_row(1'b1, 2, 50, 1'b0, 8'd0, -1);

        fill_row(0, 0);
        send_row(1'b0, 2, -1, 1'b1, 8'd0, -1);
        send_row(1'b0, 2, -1, 1'b0, 8'd1, -1);

        send_row(1'b0, 2, -1, 1'b0, 8'd0, 100);
        check("post_reset_row_idx", 32'(row_idx), 32'd0);
        fill_row(1, 0);
        send_row(1'b1, 2, -1, 1'b0, 8'd1, -1);

        // N=8 instance free-runs to show the row index wrap
        s8_done  = 1'b1;
        s8_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            guard = 0;
            @(negedge clk);
            while (!s8_start && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("wrap_row%0d", k), {29'd0, s8_row}, 32'(k % 8));
        end
        s8_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
